// File: rtl/stack_pointer_unit.sv
// Stack pointer unit: a pre-decrement push / post-increment pop pointer over
// [MEM_BASE, MEM_TOP], with a parallel load, sticky error flags and a
// combinational address for the stack access in the current cycle.
// All state changes on the falling edge of Clock; reset is synchronous, active-low.
module stack_pointer_unit #(
    parameter int WIDTH    = 16,
    parameter int MEM_TOP  = 64,
    parameter int MEM_BASE = 0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] R,
    input  logic             Rin,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic             bad_load
);

    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MEM_TOP);
    localparam logic [WIDTH-1:0] BASE = WIDTH'(MEM_BASE);
    localparam logic [WIDTH-1:0] SPAN = WIDTH'(MEM_TOP - MEM_BASE);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             bad_load_q, bad_load_d;
    logic [WIDTH-1:0] r_off;
    logic             load_ok;

    // Status derived from the pointer alone, so it tracks Q with no extra latency.
    assign full  = (q_q == BASE);
    assign empty = (q_q == TOP);
    assign count = TOP - q_q;

    assign Q         = q_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign bad_load  = bad_load_q;

    // Offset from the base wraps for R < BASE, so a single unsigned compare
    // against the span covers both bounds.
    assign r_off   = R - BASE;
    assign load_ok = (r_off <= SPAN);

    // Next-state and access address: load > push+pop > push > pop > hold.
    always_comb begin
        q_d         = q_q;
        addr        = q_q;
        overflow_d  = overflow_q  & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        bad_load_d  = bad_load_q  & ~clr_err;
        if (Rin) begin
            if (load_ok) q_d        = R;
            else         bad_load_d = 1'b1;
        end else if (push && pop) begin
            // Replace-top when there is a top; on an empty stack it degrades
            // to a plain push (empty and full are mutually exclusive).
            if (empty) begin
                q_d  = q_q - ONE;
                addr = q_q - ONE;
            end
        end else if (push) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                q_d  = q_q - ONE;
                addr = q_q - ONE;
            end
        end else if (pop) begin
            if (empty) underflow_d = 1'b1;
            else       q_d         = q_q + ONE;
        end
    end

    // Falling-edge state register with synchronous active-low reset.
    always_ff @(negedge Clock) begin
        if (!Resetn) begin
            q_q         <= TOP;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            bad_load_q  <= 1'b0;
        end else begin
            q_q         <= q_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            bad_load_q  <= bad_load_d;
        end
    end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Bench for stack_pointer_unit: one shared stimulus stream drives a default
// instance (16-bit, 64/0) and a narrow instance (8-bit, 200/100); each is
// compared against an integer reference model of the stack rules.
module tb_stack_pointer_unit;

    logic        Clock = 1'b0;
    logic        Resetn, Rin, push, pop, clr_err;
    logic [15:0] R;

    logic [15:0] q0, a0, c0;
    logic        f0, e0, o0, u0, b0;
    logic [7:0]  q1, a1, c1;
    logic        f1, e1, o1, u1, b1;

    int nvec = 0;
    int nerr = 0;

    // Reference model state, index 0 = default instance, 1 = narrow instance.
    int top [2] = '{64, 200};
    int base[2] = '{0, 100};
    int wid [2] = '{16, 8};
    int mq[2], mo[2], mu[2], mb[2];

    stack_pointer_unit u_d0 (
        .Clock(Clock), .Resetn(Resetn), .R(R), .Rin(Rin), .push(push), .pop(pop),
        .clr_err(clr_err), .Q(q0), .addr(a0), .count(c0), .full(f0), .empty(e0),
        .overflow(o0), .underflow(u0), .bad_load(b0)
    );

    stack_pointer_unit #(.WIDTH(8), .MEM_TOP(200), .MEM_BASE(100)) u_d1 (
        .Clock(Clock), .Resetn(Resetn), .R(R[7:0]), .Rin(Rin), .push(push), .pop(pop),
        .clr_err(clr_err), .Q(q1), .addr(a1), .count(c1), .full(f1), .empty(e1),
        .overflow(o1), .underflow(u1), .bad_load(b1)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Address the stack access should use this cycle, given the current pointer.
    function automatic int exp_addr(input int k);
        if (Rin) return mq[k];
        if (push && pop) return (mq[k] == top[k]) ? mq[k] - 1 : mq[k];
        if (push) return (mq[k] == base[k]) ? mq[k] : mq[k] - 1;
        return mq[k];
    endfunction

    // One falling edge of the stack rules applied to model k.
    task automatic model_edge(input int k);
        int rv;
        if (!Resetn) begin
            mq[k] = top[k]; mo[k] = 0; mu[k] = 0; mb[k] = 0;
            return;
        end
        if (clr_err) begin mo[k] = 0; mu[k] = 0; mb[k] = 0; end
        rv = int'(R) % (1 << wid[k]);
        if (Rin) begin
            if (rv >= base[k] && rv <= top[k]) mq[k] = rv;
            else mb[k] = 1;
        end else if (push && pop) begin
            if (mq[k] == top[k]) mq[k] = mq[k] - 1;
        end else if (push) begin
            if (mq[k] == base[k]) mo[k] = 1;
            else mq[k] = mq[k] - 1;
        end else if (pop) begin
            if (mq[k] == top[k]) mu[k] = 1;
            else mq[k] = mq[k] + 1;
        end
    endtask

    task automatic check_state();
        chk("q0", 32'(q0), mq[0]);
        chk("count0", 32'(c0), top[0] - mq[0]);
        chk("full0", 32'(f0), mq[0] == base[0]);
        chk("empty0", 32'(e0), mq[0] == top[0]);
        chk("ovf0", 32'(o0), mo[0]);
        chk("unf0", 32'(u0), mu[0]);
        chk("bad0", 32'(b0), mb[0]);
        chk("q1", 32'(q1), mq[1]);
        chk("count1", 32'(c1), top[1] - mq[1]);
        chk("full1", 32'(f1), mq[1] == base[1]);
        chk("empty1", 32'(e1), mq[1] == top[1]);
        chk("ovf1", 32'(o1), mo[1]);
        chk("unf1", 32'(u1), mu[1]);
        chk("bad1", 32'(b1), mb[1]);
    endtask

    // Drive one cycle: check the combinational address before the edge,
    // then the registered state just after it.
    task automatic step(input logic rst_n, input logic rin, input int r,
                        input logic ps, input logic pp, input logic clr);
        Resetn = rst_n; Rin = rin; R = 16'(r); push = ps; pop = pp; clr_err = clr;
        #1;
        if (rst_n) begin
            chk("addr0", 32'(a0), exp_addr(0));
            chk("addr1", 32'(a1), exp_addr(1));
        end
        @(negedge Clock);
        model_edge(0);
        model_edge(1);
        #1;
        check_state();
    endtask

    initial begin
        // Reset and idle: empty, count 0, addr = top.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_q0", 32'(q0), 64);
        chk("rst_addr0", 32'(a0), 64);
        chk("rst_e0", 32'(e0), 1);

        // Three pushes walk the pointer down from 64.
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        chk("push3_q0", 32'(q0), 61);
        chk("push3_cnt0", 32'(c0), 3);

        // Pop from empty sets underflow; clr_err clears it.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("unf_set0", 32'(u0), 1);
        step(1, 0, 0, 0, 0, 1);
        chk("unf_clr0", 32'(u0), 0);

        // Load 1, push to full, push into overflow, then replace-top.
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        chk("full_q0", 32'(q0), 0);
        step(1, 0, 0, 1, 0, 0);
        chk("ovf_set0", 32'(o0), 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1, 0);
        chk("repl_ovf0", 32'(o0), 0);

        // Out-of-range load, then load with a concurrent push.
        step(1, 1, 65, 0, 0, 0);
        chk("badld_q0", 32'(q0), 0);
        chk("badld0", 32'(b0), 1);
        step(1, 1, 10, 1, 0, 0);
        chk("ldpush_q0", 32'(q0), 10);

        // A new overflow beats a same-cycle clr_err.
        step(1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 1);
        chk("ovf_wins0", 32'(o0), 1);
        chk("clr_other0", 32'(b0), 0);

        // Narrow instance: 100 pushes reach the base, the 101st overflows.
        step(0, 0, 0, 0, 0, 0);
        chk("rst_q1", 32'(q1), 200);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 1, 0, 0);
        chk("full_q1", 32'(q1), 100);
        chk("full1_c", 32'(f1), 1);
        step(1, 0, 0, 1, 0, 0);
        chk("ovf_q1", 32'(q1), 100);
        chk("ovf1_c", 32'(o1), 1);

        // Reset with every request active leaves no flag behind.
        step(0, 1, 300, 1, 1, 0);
        chk("rst_ops_ovf0", 32'(o0), 0);
        chk("rst_ops_bad0", 32'(b0), 0);

        // Randomized traffic with occasional resets and error clears.
        for (int i = 0; i < 600; i++) begin
            int op;
            op = $urandom_range(0, 19);
            step(op != 0, op inside {[1:2]}, $urandom_range(0, 260),
                 op inside {[3:10]} || op == 15, op inside {[11:15]},
                 $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
